// File: rtl/svi_array_seq_if.sv
// One channel of the sequenced array: three registered W-bit members.
// The sequencer drives through master; consumers read through slave.
interface I #(
    parameter int W = 1
);
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] z;

    modport master (output x, y, z);
    modport slave  (input  x, y, z);
endinterface

// File: rtl/svi_array_seq.sv
// Walks NCH channels one per cycle after a start and rewrites the masked ones.
// Channel k is written k+1 cycles after acceptance; starts while busy are dropped (no queueing).
module svi_array_seq #(
    parameter int             NCH     = 8,
    parameter int             W       = 1,
    parameter logic [W-1:0]   X_CONST = '0,
    parameter logic [W-1:0]   Y_STEP  = W'(1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_start,
    input  logic [W-1:0]             i_data,
    input  logic [NCH-1:0]           i_mask,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [$clog2(NCH)-1:0]   o_idx,
    I.master                         u_I [NCH-1:0]
);

    localparam int IW = $clog2(NCH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_n;
    logic [IW-1:0]   idx_q, idx_n;
    logic [NCH-1:0]  mask_q;
    logic [W-1:0]    data_q;
    logic            latch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            mask_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_n;
            idx_q   <= idx_n;
            if (latch) begin
                mask_q <= i_mask;
                data_q <= i_data;
            end
        end
    end

    always_comb begin
        state_n = state_q;
        idx_n   = idx_q;
        latch   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    if (|i_mask) begin
                        latch   = 1'b1;
                        idx_n   = '0;
                        state_n = SCAN;
                    end else begin
                        // Nothing to walk: report completion straight away.
                        state_n = DONE;
                    end
                end
            end
            SCAN: begin
                if (idx_q == IW'(NCH - 1)) begin
                    idx_n   = '0;
                    state_n = DONE;
                end else begin
                    idx_n = idx_q + IW'(1);
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs decode registered state only, so no input reaches them combinationally.
    assign o_busy = (state_q == SCAN) || (state_q == DONE);
    assign o_done = (state_q == DONE);
    assign o_idx  = idx_q;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic wr;
        assign wr = (state_q == SCAN) && (idx_q == IW'(g)) && mask_q[g];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                u_I[g].x <= X_CONST;
                u_I[g].y <= '0;
                u_I[g].z <= '0;
            end else if (wr) begin
                u_I[g].x <= X_CONST;
                u_I[g].y <= u_I[g].y + Y_STEP;
                u_I[g].z <= data_q;
            end
        end
    end

endmodule

// File: tb/tb_svi_array_seq.sv
// Bench for svi_array_seq: table-driven scans, random scans with noisy inputs,
// y wrap-around and a reset landing in the middle of a scan.
module tb_svi_array_seq;

    localparam int          NCH = 8;
    localparam int          W   = 4;
    localparam logic [3:0]  XC  = 4'hA;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           i_start = 1'b0;
    logic [W-1:0]   i_data = '0;
    logic [NCH-1:0] i_mask = '0;
    logic           o_busy, o_done;
    logic [2:0]     o_idx;

    I #(.W(W)) u_I [NCH-1:0] ();

    svi_array_seq #(
        .NCH(NCH), .W(W), .X_CONST(XC), .Y_STEP(4'd1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_data(i_data),
        .i_mask(i_mask), .o_busy(o_busy), .o_done(o_done), .o_idx(o_idx),
        .u_I(u_I)
    );

    always #5 clk = ~clk;

    logic [W-1:0] ax [NCH];
    logic [W-1:0] ay [NCH];
    logic [W-1:0] az [NCH];
    for (genvar g = 0; g < NCH; g++) begin : g_tap
        assign ax[g] = u_I[g].x;
        assign ay[g] = u_I[g].y;
        assign az[g] = u_I[g].z;
    end

    // Reference: channel contents as the scan rules say they must be.
    logic [W-1:0] mx [NCH];
    logic [W-1:0] my [NCH];
    logic [W-1:0] mz [NCH];

    int nchk = 0;
    int nfail = 0;

    typedef struct {
        logic [NCH-1:0] mask;
        logic [W-1:0]   data;
        int             done_cyc;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            mx[k] = XC;
            my[k] = '0;
            mz[k] = '0;
        end
    endtask

    task automatic chk_chan(input string nm);
        int bad;
        bad = -1;
        nchk++;
        for (int k = 0; k < NCH; k++)
            if (bad < 0 && (ax[k] !== mx[k] || ay[k] !== my[k] || az[k] !== mz[k]))
                bad = k;
        if (bad >= 0) begin
            nfail++;
            $display("FAIL %s ch%0d: got x=%h y=%h z=%h expected x=%h y=%h z=%h",
                     nm, bad, ax[bad], ay[bad], az[bad], mx[bad], my[bad], mz[bad]);
        end
    endtask

    // One accepted start, then cycle-by-cycle checks until one idle cycle after DONE.
    // With noisy set, inputs churn during the scan and a start is offered in the DONE cycle.
    task automatic do_scan(input logic [NCH-1:0] m, input logic [W-1:0] d,
                           input int exp_dc, input bit noisy, input string nm);
        @(negedge clk);
        i_start = 1'b1;
        i_mask  = m;
        i_data  = d;
        for (int c = 1; c <= exp_dc + 1; c++) begin
            @(negedge clk);
            if (m != 0 && c >= 2 && c - 2 < NCH && m[c-2]) begin
                mx[c-2] = XC;
                my[c-2] = my[c-2] + 4'd1;
                mz[c-2] = d;
            end
            chk({nm, "_busy"}, o_busy, (c <= exp_dc));
            chk({nm, "_done"}, o_done, (c == exp_dc));
            chk({nm, "_idx"},  o_idx,  (m != 0 && c <= NCH) ? c - 1 : 0);
            chk_chan({nm, "_chan"});
            if (noisy && c < exp_dc) begin
                i_start = 1'($urandom_range(0, 1));
                i_mask  = NCH'($urandom);
                i_data  = W'($urandom);
            end else if (noisy && c == exp_dc) begin
                i_start = 1'b1;
                i_mask  = '1;
                i_data  = W'($urandom);
            end else begin
                i_start = 1'b0;
            end
        end
        i_start = 1'b0;
    endtask

    vec_t tbl [5];

    initial begin
        logic [NCH-1:0] m;
        int any_done;

        tbl[0] = '{8'hFF, 4'h5, NCH + 1};
        tbl[1] = '{8'h05, 4'h3, NCH + 1};
        tbl[2] = '{8'h00, 4'h7, 1};
        tbl[3] = '{8'h80, 4'hC, NCH + 1};
        tbl[4] = '{8'h3C, 4'h0, NCH + 1};

        model_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_idx",  o_idx,  0);
        chk_chan("rst_chan");

        for (int i = 0; i < 5; i++)
            do_scan(tbl[i].mask, tbl[i].data, tbl[i].done_cyc, i[0], $sformatf("tbl%0d", i));

        for (int i = 0; i < 10; i++) begin
            m = NCH'($urandom);
            if (i == 3) m = '0;
            do_scan(m, W'($urandom), (m == 0) ? 1 : NCH + 1, 1'b1, $sformatf("rnd%0d", i));
        end

        // Wrap: from reset, 16 full scans bring every y back to 0.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 15; i++)
            do_scan('1, W'($urandom), NCH + 1, 1'b0, "wrap");
        chk("wrap_yF", ay[3], 4'hF);
        do_scan('1, 4'h9, NCH + 1, 1'b0, "wrap16");
        for (int k = 0; k < NCH; k++)
            chk($sformatf("wrap_y0_%0d", k), ay[k], 4'h0);

        // Reset arriving in scan cycle 3 discards the scan and suppresses DONE.
        @(negedge clk);
        i_start = 1'b1;
        i_mask  = '1;
        i_data  = 4'h6;
        @(negedge clk);
        i_start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_busy", o_busy, 0);
        chk("mid_done", o_done, 0);
        chk("mid_idx",  o_idx,  0);
        chk_chan("mid_chan");
        @(negedge clk);
        rst_n = 1'b1;
        any_done = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (o_done === 1'b1) any_done++;
        end
        chk("mid_nodone", any_done, 0);
        chk_chan("mid_hold");
        do_scan(8'h42, 4'hE, NCH + 1, 1'b0, "post");

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
